key_debounce_conditioner: RTL and testbench

- Conditions the four raw DE2-115 pushbutton pins (active-low, mechanically bouncing) before they reach the Nios keys PIO input (keys_export, 4 bits).
- Per key, in this order: 2-flop synchroniser, time-qualified debounce FSM, single-cycle press/release event pulses.
- Instantiated at top level between the KEY pins and nios_system; the debounced level drives keys_export, and the pulses are available to other fabric logic.

---
 rtl/key_debounce_conditioner.sv | 165 ++++++++++++++++
 tb/tb_key_debounce_conditioner.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/key_debounce_conditioner.sv
// Pushbutton conditioner: 2-flop synchroniser, time-qualified debounce FSM and press/release
// pulses per key. Define KEY_AUTOREPEAT_EN to add hold-to-repeat press pulses.
module key_debounce_conditioner #(
  parameter int unsigned NUM_KEYS        = 4,
  parameter int unsigned CLK_HZ          = 50000000,
  parameter int unsigned DEBOUNCE_MS     = 10,
  parameter int unsigned REPEAT_DELAY_MS = 500,
  parameter int unsigned REPEAT_RATE_MS  = 100
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  input  logic [NUM_KEYS-1:0] key_n_raw,
  output logic [NUM_KEYS-1:0] keys_export,
  output logic [NUM_KEYS-1:0] key_press_pulse,
  output logic [NUM_KEYS-1:0] key_release_pulse,
  output logic                key_any_event
);

  localparam int unsigned CNT_MAX = (CLK_HZ / 1000) * DEBOUNCE_MS;
  localparam int unsigned CW      = $clog2(CNT_MAX) + 1;

  typedef logic [CW-1:0] cnt_t;
  typedef enum logic [1:0] {StReleased, StPressPend, StPressed, StReleasePend} state_e;

  localparam cnt_t CNT_LAST = cnt_t'(CNT_MAX - 1);

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    logic   sync1_q, sync2_q;
    state_e state_q, state_d;
    cnt_t   cnt_q, cnt_d;
    logic   level_q, level_d;
    logic   press_q, press_d;
    logic   rel_q, rel_d;
    logic   rpt_fire;

    always_ff @(posedge clk_clk) begin
      if (!reset_reset) begin
        sync1_q <= 1'b1;
        sync2_q <= 1'b1;
        state_q <= StReleased;
        cnt_q   <= '0;
        level_q <= 1'b1;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        sync1_q <= key_n_raw[g];
        sync2_q <= sync1_q;
        state_q <= state_d;
        cnt_q   <= cnt_d;
        level_q <= level_d;
        press_q <= press_d;
        rel_q   <= rel_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      unique case (state_q)
        StReleased: begin
          if (!sync2_q) begin
            state_d = StPressPend;
            cnt_d   = cnt_t'(1);
          end
        end
        StPressPend: begin
          if (sync2_q) begin
            state_d = StReleased;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = StPressed;
            level_d = 1'b0;
            press_d = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + cnt_t'(1);
          end
        end
        StPressed: begin
          if (sync2_q) begin
            state_d = StReleasePend;
            cnt_d   = cnt_t'(1);
          end else begin
            press_d = rpt_fire;
          end
        end
        StReleasePend: begin
          if (!sync2_q) begin
            state_d = StPressed;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = StReleased;
            level_d = 1'b1;
            rel_d   = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + cnt_t'(1);
          end
        end
        default: begin
          state_d = StReleased;
          cnt_d   = '0;
        end
      endcase
    end

`ifdef KEY_AUTOREPEAT_EN
    localparam int unsigned RPT_DELAY = (CLK_HZ / 1000) * REPEAT_DELAY_MS;
    localparam int unsigned RPT_RATE  = (CLK_HZ / 1000) * REPEAT_RATE_MS;
    localparam int unsigned RPT_MAX   = (RPT_DELAY > RPT_RATE) ? RPT_DELAY : RPT_RATE;
    localparam int unsigned RW        = $clog2(RPT_MAX) + 1;
    typedef logic [RW-1:0] rpt_t;

    rpt_t rpt_q, rpt_d;
    logic first_q, first_d;

    always_ff @(posedge clk_clk) begin
      if (!reset_reset) begin
        rpt_q   <= '0;
        first_q <= 1'b1;
      end else begin
        rpt_q   <= rpt_d;
        first_q <= first_d;
      end
    end

    // Counts only while steadily pressed; frozen in StReleasePend, cleared once released.
    always_comb begin
      rpt_d    = rpt_q;
      first_d  = first_q;
      rpt_fire = 1'b0;
      if (state_q == StPressed && !sync2_q) begin
        if (rpt_q == (first_q ? rpt_t'(RPT_DELAY - 1) : rpt_t'(RPT_RATE - 1))) begin
          rpt_fire = 1'b1;
          rpt_d    = '0;
          first_d  = 1'b0;
        end else begin
          rpt_d = rpt_q + rpt_t'(1);
        end
      end else if (state_q == StReleased) begin
        rpt_d   = '0;
        first_d = 1'b1;
      end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    assign keys_export[g]       = level_q;
    assign key_press_pulse[g]   = press_q;
    assign key_release_pulse[g] = rel_q;
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset) begin
      key_any_event <= 1'b0;
    end else begin
      key_any_event <= |(key_press_pulse | key_release_pulse);
    end
  end

endmodule

// File: tb/tb_key_debounce_conditioner.sv
// Scoreboard bench for key_debounce_conditioner: a per-cycle expectation from a run-length
// debounce model is queued by the stimulus process and checked by an independent monitor.
module tb_key_debounce_conditioner;

  localparam int CNT   = 8;
  localparam int DELAY = 20;
  localparam int RATE  = 5;

  logic       clk_clk;
  logic       reset_reset;
  logic [3:0] key_n_raw;
  logic [3:0] keys_export;
  logic [3:0] key_press_pulse;
  logic [3:0] key_release_pulse;
  logic       key_any_event;

  key_debounce_conditioner #(
    .NUM_KEYS        (4),
    .CLK_HZ          (1000),
    .DEBOUNCE_MS     (8),
    .REPEAT_DELAY_MS (20),
    .REPEAT_RATE_MS  (5)
  ) dut (
    .clk_clk           (clk_clk),
    .reset_reset       (reset_reset),
    .key_n_raw         (key_n_raw),
    .keys_export       (keys_export),
    .key_press_pulse   (key_press_pulse),
    .key_release_pulse (key_release_pulse),
    .key_any_event     (key_any_event)
  );

  initial begin
    clk_clk = 1'b0;
    forever #5 clk_clk = ~clk_clk;
  end

  // Reference state: two-stage delay of the raw pins, debounced level, length of the current
  // disagreement run, and cycles held while steadily pressed.
  logic [3:0]  m_s1, m_s2, m_lvl, m_press, m_rel;
  logic        m_any;
  int          run  [4];
  int          held [4];
  logic [12:0] exp_q [$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          n_press_seen = 0;

  task automatic model_step(input logic rst, input logic [3:0] k);
    logic [3:0] np, nr;
    logic       na;
    if (!rst) begin
      m_s1 = '1; m_s2 = '1; m_lvl = '1; m_press = '0; m_rel = '0; m_any = 1'b0;
      for (int i = 0; i < 4; i++) begin
        run[i]  = 0;
        held[i] = 0;
      end
    end else begin
      na = |(m_press | m_rel);
      np = '0;
      nr = '0;
      for (int i = 0; i < 4; i++) begin
        if (m_s2[i] != m_lvl[i]) begin
          run[i]++;
          if (run[i] == CNT) begin
            m_lvl[i] = m_s2[i];
            run[i]   = 0;
            held[i]  = 0;
            if (m_s2[i] == 1'b0) np[i] = 1'b1;
            else                 nr[i] = 1'b1;
          end
        end else if (run[i] != 0) begin
          run[i] = 0;
        end else if (m_lvl[i] == 1'b0) begin
          held[i]++;
`ifdef KEY_AUTOREPEAT_EN
          if (held[i] == DELAY || (held[i] > DELAY && (held[i] - DELAY) % RATE == 0)) np[i] = 1'b1;
`endif
        end
      end
      m_s2 = m_s1;
      m_s1 = k;
      m_press = np;
      m_rel   = nr;
      m_any   = na;
    end
    exp_q.push_back({m_lvl, m_press, m_rel, m_any});
  endtask

  task automatic step(input logic rst, input logic [3:0] k);
    @(negedge clk_clk);
    reset_reset = rst;
    key_n_raw   = k;
    @(posedge clk_clk);
    model_step(rst, k);
  endtask

  task automatic hold(input logic rst, input logic [3:0] k, input int n);
    for (int i = 0; i < n; i++) step(rst, k);
  endtask

  // Monitor: compares every cycle's outputs against the queued expectation.
  initial begin
    logic [12:0] exp_v, got_v;
    forever begin
      @(posedge clk_clk);
      #1;
      if (exp_q.size() != 0) begin
        exp_v = exp_q.pop_front();
        got_v = {keys_export, key_press_pulse, key_release_pulse, key_any_event};
        n_vec++;
        if (key_press_pulse[0]) n_press_seen++;
        if (got_v !== exp_v) begin
          n_bad++;
          $display("FAIL outputs t=%0t got {keys,press,rel,any}=%b_%b_%b_%b expected %b_%b_%b_%b",
                   $time, got_v[12:9], got_v[8:5], got_v[4:1], got_v[0],
                   exp_v[12:9], exp_v[8:5], exp_v[4:1], exp_v[0]);
        end
      end
    end
  end

  initial begin
    logic [3:0] k;
    int         p0;
    reset_reset = 1'b0;
    key_n_raw   = 4'hF;
    hold(1'b0, 4'h0, 3);          // reset with keys held low
    hold(1'b1, 4'h0, 15);         // all four press on edge 10
    hold(1'b1, 4'hF, 15);
    hold(1'b1, 4'hE, 15);         // clean press key 0
    hold(1'b1, 4'hF, 15);
    for (int i = 0; i < 8; i++) begin   // bounce key 1, settle high
      hold(1'b1, 4'hD, 3);
      hold(1'b1, 4'hF, 2);
    end
    hold(1'b1, 4'hF, 15);
    for (int i = 0; i < 8; i++) begin   // bounce key 1, settle low
      hold(1'b1, 4'hD, 3);
      hold(1'b1, 4'hF, 2);
    end
    hold(1'b1, 4'hD, 15);
    hold(1'b1, 4'hF, 15);
    hold(1'b1, 4'hE, 7);          // one short of threshold
    hold(1'b1, 4'hF, 15);
    hold(1'b1, 4'hE, 8);          // exactly threshold
    hold(1'b1, 4'hF, 15);
    hold(1'b1, 4'h3, 15);         // keys 2 and 3 together
    hold(1'b1, 4'hF, 15);
    hold(1'b1, 4'hE, 6);          // reset during press qualification
    hold(1'b0, 4'hE, 2);
    hold(1'b1, 4'hF, 15);
    p0 = n_press_seen;
    hold(1'b1, 4'hE, 50);         // long hold key 0
    hold(1'b1, 4'hF, 15);
    @(posedge clk_clk);
    #2;
`ifdef KEY_AUTOREPEAT_EN
    if (n_press_seen - p0 != 6) begin
      n_bad++;
      $display("FAIL hold_press_count got %0d required 6", n_press_seen - p0);
    end
`else
    if (n_press_seen - p0 != 1) begin
      n_bad++;
      $display("FAIL hold_press_count got %0d required 1", n_press_seen - p0);
    end
`endif
    n_vec++;
    k = 4'hF;
    for (int c = 0; c < 2000; c++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 7) == 0) k[b] = ~k[b];
      end
      step(($urandom_range(0, 499) != 0), k);
    end
    @(posedge clk_clk);
    #2;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain got %0d pending required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
